// File: rtl/aes_rkey_reverse_buffer_if.sv
// Roundkey buffer bus: expander load port, replay control/status and the
// roundkey stream towards the decrypt round engine.
interface aes_rkey_reverse_buffer_if #(
  parameter int KW = 128
);
  logic [0:KW-1] rkey_in;
  logic          rkey_in_vld;
  logic          rkey_in_last;
  logic          key_valid;
  logic          key_err;
  logic          start;
  logic          busy;
  logic [0:KW-1] rk_out;
  logic          rk_vld;
  logic          rk_rdy;
  logic          rk_first;
  logic          rk_last;

  modport master (
    output rkey_in, rkey_in_vld, rkey_in_last, start, rk_rdy,
    input  key_valid, key_err, busy, rk_out, rk_vld, rk_first, rk_last
  );

  modport slave (
    input  rkey_in, rkey_in_vld, rkey_in_last, start, rk_rdy,
    output key_valid, key_err, busy, rk_out, rk_vld, rk_first, rk_last
  );
endinterface

// File: rtl/aes_rkey_reverse_buffer.sv
// Stores a forward-order roundkey schedule (key 0 first) and replays it
// last-key-first, once per start, to the inverse cipher datapath.
module aes_rkey_reverse_buffer #(
  parameter int NR = 14,
  parameter int KW = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  aes_rkey_reverse_buffer_if.slave   io
);
  localparam int IW = (NR > 0) ? $clog2(NR + 1) : 1;
  localparam logic [IW-1:0] NR_I = IW'(NR);

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_READY, S_REPLAY} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic          key_valid_q, key_valid_d;
  logic          key_err_q, key_err_d;
  logic          rk_vld_q, rk_vld_d;
  logic          rk_first_q, rk_first_d;
  logic          rk_last_q, rk_last_d;
  logic [0:KW-1] rk_out_q, rk_out_d;
  logic [0:KW-1] mem_q [0:NR];

  logic          ld_start, in_load_beat, at_end, load_done, load_err;
  logic          wr_en, rep_go, xfer, rep_end;
  logic [IW-1:0] wr_addr, rd_prev;

  // Event decode shared by the next-state and datapath processes. A new
  // beat outside LOAD always restarts the schedule at entry 0.
  always_comb begin
    ld_start     = io.rkey_in_vld && (state_q != S_LOAD);
    in_load_beat = io.rkey_in_vld && (state_q == S_LOAD);
    at_end       = (wr_idx_q == NR_I);
    load_done    = (in_load_beat && io.rkey_in_last && at_end) ||
                   (ld_start && io.rkey_in_last && (NR_I == '0));
    load_err     = (in_load_beat && (io.rkey_in_last != at_end)) ||
                   (ld_start && io.rkey_in_last && (NR_I != '0));
    // An overlong schedule's extra beat would land past the last entry.
    wr_en        = !rst && (ld_start || (in_load_beat && !(at_end && !io.rkey_in_last)));
    wr_addr      = ld_start ? '0 : wr_idx_q;
    rep_go       = (state_q == S_READY) && io.start && !io.rkey_in_vld;
    xfer         = (state_q == S_REPLAY) && io.rk_rdy && !io.rkey_in_vld;
    rep_end      = xfer && (rd_idx_q == '0);
    rd_prev      = rd_idx_q - IW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= io.rkey_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      rk_vld_q    <= 1'b0;
      rk_first_q  <= 1'b0;
      rk_last_q   <= 1'b0;
      rk_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      key_valid_q <= key_valid_d;
      key_err_q   <= key_err_d;
      rk_vld_q    <= rk_vld_d;
      rk_first_q  <= rk_first_d;
      rk_last_q   <= rk_last_d;
      rk_out_q    <= rk_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load_err)       state_d = S_EMPTY;
    else if (load_done) state_d = S_READY;
    else if (ld_start)  state_d = S_LOAD;
    else if (rep_go)    state_d = S_REPLAY;
    else if (rep_end)   state_d = S_READY;
  end

  always_comb begin
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    key_valid_d = key_valid_q;
    key_err_d   = key_err_q;
    rk_vld_d    = rk_vld_q;
    rk_first_d  = rk_first_q;
    rk_last_d   = rk_last_q;
    rk_out_d    = rk_out_q;

    if (ld_start)          wr_idx_d = IW'(1);
    else if (in_load_beat) wr_idx_d = wr_idx_q + IW'(1);

    if (ld_start)  key_valid_d = 1'b0;
    if (load_done) key_valid_d = 1'b1;
    if (load_err)  key_err_d   = 1'b1;
    if (load_done) key_err_d   = 1'b0;

    // Any load beat kills an in-flight replay, whatever rk_rdy says.
    if (io.rkey_in_vld) begin
      rk_vld_d   = 1'b0;
      rk_first_d = 1'b0;
      rk_last_d  = 1'b0;
    end else if (rep_go) begin
      rd_idx_d   = NR_I;
      rk_out_d   = mem_q[NR_I];
      rk_vld_d   = 1'b1;
      rk_first_d = 1'b1;
      rk_last_d  = (NR_I == '0);
    end else if (rep_end) begin
      rk_vld_d   = 1'b0;
      rk_first_d = 1'b0;
      rk_last_d  = 1'b0;
    end else if (xfer) begin
      rd_idx_d   = rd_prev;
      rk_out_d   = mem_q[rd_prev];
      rk_first_d = 1'b0;
      rk_last_d  = (rd_prev == '0);
    end
  end

  assign io.key_valid = key_valid_q;
  assign io.key_err   = key_err_q;
  assign io.busy      = (state_q == S_REPLAY);
  assign io.rk_out    = rk_out_q;
  assign io.rk_vld    = rk_vld_q;
  assign io.rk_first  = rk_first_q;
  assign io.rk_last   = rk_last_q;
endmodule

// File: tb/tb_aes_rkey_reverse_buffer.sv
// Directed bench: loads, replays, error schedules, abort and reset, with a
// queue-based scoreboard checking every presented roundkey.
module tb_aes_rkey_reverse_buffer;
  localparam int NR = 14;
  localparam int KW = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_rkey_reverse_buffer_if #(.KW(KW)) bus();

  aes_rkey_reverse_buffer #(.NR(NR), .KW(KW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  typedef struct {
    logic [127:0] data;
    logic         first;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every presented beat must match the queue head; on
  // a stall the head is not popped, so the held value is rechecked.
  always @(negedge clk) begin
    if (!rst && bus.rk_vld && !bus.rkey_in_vld) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_beat: got rk_out %h expected no beat", bus.rk_out);
      end else begin
        chk(bus.rk_rdy ? "rk_out" : "stall_rk_out", bus.rk_out, exp_q[0].data);
        chk(bus.rk_rdy ? "rk_first" : "stall_rk_first", 128'(bus.rk_first), 128'(exp_q[0].first));
        chk(bus.rk_rdy ? "rk_last" : "stall_rk_last", 128'(bus.rk_last), 128'(exp_q[0].last));
        if (bus.rk_rdy) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_expect(input logic [7:0] base);
    logic [7:0] v;
    for (int k = NR; k >= 0; k--) begin
      v = base + 8'(k);
      exp_q.push_back('{data: {16{v}}, first: (k == NR), last: (k == 0)});
    end
  endtask

  task automatic load(input logic [7:0] base, input int first_b, input int n, input int last_at);
    logic [7:0] v;
    for (int b = first_b; b < first_b + n; b++) begin
      v = base + 8'(b);
      bus.rkey_in      = {16{v}};
      bus.rkey_in_vld  = 1'b1;
      bus.rkey_in_last = (b == last_at);
      tick();
    end
    bus.rkey_in_vld  = 1'b0;
    bus.rkey_in_last = 1'b0;
  endtask

  task automatic check_idle_reset_vals(input string tag);
    chk({tag, "_key_valid"}, 128'(bus.key_valid), 128'(0));
    chk({tag, "_key_err"},   128'(bus.key_err),   128'(0));
    chk({tag, "_busy"},      128'(bus.busy),      128'(0));
    chk({tag, "_rk_vld"},    128'(bus.rk_vld),    128'(0));
    chk({tag, "_rk_first"},  128'(bus.rk_first),  128'(0));
    chk({tag, "_rk_last"},   128'(bus.rk_last),   128'(0));
    chk({tag, "_rk_out"},    bus.rk_out,          128'(0));
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Full replay; returns after the cycle in which busy must have dropped.
  task automatic replay(input logic [7:0] base, input bit rand_rdy);
    int cnt;
    push_expect(base);
    bus.rk_rdy = 1'b0;
    pulse_start();
    chk("start_rk_vld", 128'(bus.rk_vld), 128'(1));
    chk("start_busy",   128'(bus.busy),   128'(1));
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 300) begin
      bus.rk_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cnt++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL replay_timeout: got %0d keys pending expected 0", exp_q.size());
      exp_q.delete();
    end
    bus.rk_rdy = 1'b0;
    chk("replay_end_busy",   128'(bus.busy),   128'(0));
    chk("replay_end_rk_vld", 128'(bus.rk_vld), 128'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end

  initial begin
    bus.rkey_in      = '0;
    bus.rkey_in_vld  = 1'b0;
    bus.rkey_in_last = 1'b0;
    bus.start        = 1'b0;
    bus.rk_rdy       = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check_idle_reset_vals("reset");
    rst = 1'b0;

    // start with nothing loaded
    pulse_start();
    tick();
    chk("empty_start_busy", 128'(bus.busy), 128'(0));

    // good load, key i = byte i repeated
    load(8'h00, 0, 15, 14);
    chk("load_key_valid", 128'(bus.key_valid), 128'(1));
    chk("load_key_err",   128'(bus.key_err),   128'(0));

    replay(8'h00, 1'b0);
    replay(8'h00, 1'b0);
    replay(8'h00, 1'b1);
    chk("after_replay_key_valid", 128'(bus.key_valid), 128'(1));

    // short schedule
    load(8'h40, 0, 11, 10);
    chk("short_key_err",   128'(bus.key_err),   128'(1));
    chk("short_key_valid", 128'(bus.key_valid), 128'(0));
    pulse_start();
    tick();
    chk("short_start_busy",   128'(bus.busy),   128'(0));
    chk("short_start_rk_vld", 128'(bus.rk_vld), 128'(0));

    // good load clears the sticky error
    load(8'h00, 0, 15, 14);
    chk("reload_key_err",   128'(bus.key_err),   128'(0));
    chk("reload_key_valid", 128'(bus.key_valid), 128'(1));

    // long schedule: beat at the final index without last
    load(8'h50, 0, 15, -1);
    chk("long_key_err",   128'(bus.key_err),   128'(1));
    chk("long_key_valid", 128'(bus.key_valid), 128'(0));
    load(8'h00, 0, 15, 14);
    chk("reload2_key_err",   128'(bus.key_err),   128'(0));
    chk("reload2_key_valid", 128'(bus.key_valid), 128'(1));

    // abort at replay beat 5 with a new schedule
    push_expect(8'h00);
    pulse_start();
    bus.rk_rdy = 1'b1;
    repeat (5) tick();
    chk("abort_pre_rk_out", bus.rk_out, {16{8'h09}});
    load(8'hA0, 0, 1, -1);
    exp_q.delete();
    chk("abort_rk_vld",    128'(bus.rk_vld),    128'(0));
    chk("abort_busy",      128'(bus.busy),      128'(0));
    chk("abort_key_valid", 128'(bus.key_valid), 128'(0));
    load(8'hA0, 1, 14, 14);
    chk("abort_load_key_valid", 128'(bus.key_valid), 128'(1));
    replay(8'hA0, 1'b0);

    // reset at replay beat 7
    push_expect(8'hA0);
    pulse_start();
    bus.rk_rdy = 1'b1;
    repeat (7) tick();
    chk("rst_pre_rk_out", bus.rk_out, {16{8'hA7}});
    rst = 1'b1;
    tick();
    exp_q.delete();
    bus.rk_rdy = 1'b0;
    check_idle_reset_vals("midrst");
    rst = 1'b0;
    pulse_start();
    tick();
    chk("rst_start_busy",   128'(bus.busy),   128'(0));
    chk("rst_start_rk_vld", 128'(bus.rk_vld), 128'(0));

    load(8'h30, 0, 15, 14);
    chk("post_rst_key_valid", 128'(bus.key_valid), 128'(1));
    replay(8'h30, 1'b1);

    tick();
    chk("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
